qnet_input_quantizer: RTL and testbench
=======================================

// Module: qnet_input_quantizer
// PURPOSE
//  Upstream stage of the layer0 neuron array in the quantum-readout LogicNets pipeline.
//  Accepts one stream of signed readout features per shot over valid/ready.
//  Quantizes each feature to IN_BW bits.
//  Packs the codes into the flat input vector that the layer0_N* LUT neurons slice their fan-in from.
//  Double-buffered: assembly of shot k+1 overlaps the wait for layer0 to take shot k.
// PARAMETERS
//  SAMPLE_W      16   width of signed input feature sample
//  NUM_FEATURES  32   features per shot (frame length)
//  IN_BW         2    quantized bits per feature (layer0 input bitwidth)
//  SHIFT         8    right-shift defining the uniform quantizer step (2^SHIFT LSBs per code)
// PORTS
//  clk       in   1                     clock; all logic rising-edge
//  rst_n     in   1                     asynchronous active-low reset
//  s_valid   in   1                     input sample valid
//  s_ready   out  1                     input sample accepted when s_valid & s_ready
//  s_data    in   SAMPLE_W              signed feature sample, feature index = arrival order
//  s_last    in   1                     marks final sample of a shot
//  m_valid   out  1                     packed frame valid to layer0
//  m_ready   in   1                     layer0 capture; frame consumed when m_valid & m_ready
//  m_data    out  NUM_FEATURES*IN_BW    packed codes, feature i at [i*IN_BW +: IN_BW]
//  err_len   out  1                     one-cycle pulse on shot-length violation
// BEHAVIOUR
//  Reset (async assert, sync deassert assumed upstream):
//   - all-zero outputs: s_ready=0 while rst_n low, m_valid=0, m_data=0, err_len=0.
//   - idx=0, FSM=COLLECT, both buffers empty.
//   - s_ready=1 the first cycle after release.
//  Quantizer (combinational on s_data):
//   - code = (s_data<0) ? 0 : min(s_data>>>SHIFT, 2^IN_BW-1).
//   - Saturating; no rounding.
//  Assembly register A, index counter idx (clog2(NUM_FEATURES) bits):
//   - each accepted sample writes code into A slot idx and increments idx.
//  FSM states:
//   - COLLECT:
//     - s_last at idx==NUM_FEATURES-1: A complete; idx->0; go COMMIT.
//     - s_last at idx<NUM_FEATURES-1: frame dropped, err_len pulse, idx->0, stay COLLECT.
//     - no s_last at idx==NUM_FEATURES-1: err_len pulse, idx->0, go DISCARD.
//   - DISCARD:
//     - s_ready=1; samples accepted and dropped.
//     - accepted s_last -> COLLECT (no further err_len).
//   - COMMIT:
//     - s_ready=0.
//     - A copies to output register O when O empty or O consumed this cycle; then -> COLLECT.
//  Output register O:
//   - m_valid set on copy.
//   - m_data stable while m_valid & !m_ready.
//   - m_valid clears on handshake unless a new copy lands the same cycle (stays 1, new data).
//  Latency and throughput:
//   - last sample accepted at cycle t, O empty: m_valid=1 at t+2 (COMMIT copy at t+1, visible t+2).
//   - Sustained throughput is one frame per NUM_FEATURES+1 cycles.
//   - O held and A complete: s_ready stays 0 until m_ready.
//  s_ready is registered-state driven only; it never depends combinationally on s_valid.
//  Mid-operation reset: partial frame and pending O are discarded, m_valid drops immediately.
// STRUCTURE
//  Shared package qnet_pkg:
//   - state enum {COLLECT, DISCARD, COMMIT}.
//   - localparams FRAME_W=NUM_FEATURES*IN_BW, CODE_MAX=2^IN_BW-1.
//  One sub-module qnet_feature_quant: the combinational saturating quantizer (SAMPLE_W, IN_BW, SHIFT).
//  Top holds the FSM, counter, A/O registers and handshake.
// TESTING
//  (defaults; SHIFT=8, IN_BW=2)
//  1. Quantizer points: samples 0x0150, 0x0400, -5 (0xFFFB), 0x00FF map to codes 1, 3, 0, 0.
//  2. Full frame, m_ready=1, 32 samples with 0x0200 and s_last on 32nd:
//     - m_valid one cycle at t+2;
//     - m_data=64'hAAAA_AAAA_AAAA_AAAA.
//  3. Backpressure, m_ready=0 for 80 cycles, two frames sent back-to-back:
//     - 2nd frame assembles;
//     - s_ready=0 after its s_last;
//     - frame 1 data stable;
//     - on m_ready frame 2 follows with no gap.
//  4. Early s_last at sample 10:
//     - err_len pulses once, no m_valid;
//     - next 32-sample frame is correct.
//  5. Missing s_last, 40 samples with s_last on 40th:
//     - err_len one pulse at sample 32;
//     - samples 33-40 dropped; no m_valid.
//  6. Assert rst_n low mid-frame (idx=15) and while m_valid=1:
//     - m_valid=0 asynchronously;
//     - next full frame output correct.

Source files
------------

// File: rtl/qnet_pkg.sv
// Shared definitions for the layer0 input quantizer.
//   state_e        : frame assembly FSM states
//   *_DEF          : default block parameters
//   FRAME_W        : packed frame width at default parameters
//   CODE_MAX       : largest quantizer code at default parameters
//   code_max()     : largest code for an arbitrary code width
package qnet_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DISCARD = 2'd1,
    COMMIT  = 2'd2
  } state_e;

  localparam int SAMPLE_W_DEF     = 16;
  localparam int NUM_FEATURES_DEF = 32;
  localparam int IN_BW_DEF        = 2;
  localparam int SHIFT_DEF        = 8;

  localparam int FRAME_W  = NUM_FEATURES_DEF * IN_BW_DEF;
  localparam int CODE_MAX = (1 << IN_BW_DEF) - 1;

  function automatic int code_max(input int bw);
    return (1 << bw) - 1;
  endfunction

endpackage

// File: rtl/qnet_feature_quant.sv
// Combinational saturating quantizer for one signed readout feature.
//   sample : SAMPLE_W-bit two's-complement feature
//   code   : IN_BW-bit code; negatives map to 0, values at or above
//            (CODE_MAX+1)<<SHIFT saturate to CODE_MAX, otherwise the
//            sample is truncated by SHIFT (no rounding)
module qnet_feature_quant
  import qnet_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int IN_BW    = IN_BW_DEF,
  parameter int SHIFT    = SHIFT_DEF
) (
  input  logic [SAMPLE_W-1:0] sample,
  output logic [IN_BW-1:0]    code
);

  localparam logic signed [SAMPLE_W-1:0] MAX_S    = SAMPLE_W'(code_max(IN_BW));
  localparam logic        [IN_BW-1:0]    MAX_CODE = IN_BW'(code_max(IN_BW));

  function automatic logic [IN_BW-1:0] sat_code(input logic signed [SAMPLE_W-1:0] x);
    logic signed [SAMPLE_W-1:0] q;
    q = x >>> SHIFT;
    if (x < 0)
      sat_code = '0;
    else if (q > MAX_S)
      sat_code = MAX_CODE;
    else
      sat_code = q[IN_BW-1:0];
  endfunction

  assign code = sat_code($signed(sample));

endmodule

// File: rtl/qnet_input_quantizer.sv
// Input quantizer feeding the layer0 LUT neuron array.
// Collects one shot of NUM_FEATURES signed samples, quantizes each to
// IN_BW bits and presents the packed frame to layer0. Assembly register A
// and output register O form a double buffer so shot k+1 can be collected
// while layer0 has not yet taken shot k.
//   clk, rst_n      : clock, asynchronous active-low reset
//   s_valid/s_ready : sample handshake; s_data signed sample, s_last ends shot
//   m_valid/m_ready : packed frame handshake; m_data feature i at [i*IN_BW +: IN_BW]
//   err_len         : one-cycle pulse when a shot is shorter or longer than
//                     NUM_FEATURES samples
module qnet_input_quantizer
  import qnet_pkg::*;
#(
  parameter int SAMPLE_W     = SAMPLE_W_DEF,
  parameter int NUM_FEATURES = NUM_FEATURES_DEF,
  parameter int IN_BW        = IN_BW_DEF,
  parameter int SHIFT        = SHIFT_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [SAMPLE_W-1:0]           s_data,
  input  logic                          s_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [NUM_FEATURES*IN_BW-1:0] m_data,
  output logic                          err_len
);

  localparam int OUT_W = NUM_FEATURES * IN_BW;
  localparam int IDX_W = $clog2(NUM_FEATURES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_FEATURES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [OUT_W-1:0]   a_q, a_d;
  logic [OUT_W-1:0]   o_q, o_d;
  logic               o_vld_q, o_vld_d;
  logic               err_q, err_d;
  logic [IN_BW-1:0]   code;
  logic               s_fire;
  logic               m_fire;

  qnet_feature_quant #(
    .SAMPLE_W (SAMPLE_W),
    .IN_BW    (IN_BW),
    .SHIFT    (SHIFT)
  ) u_quant (
    .sample (s_data),
    .code   (code)
  );

  // Ready depends only on registered state; gating with rst_n keeps it low
  // for the whole time reset is held.
  assign s_ready = rst_n && (state_q != COMMIT);
  assign s_fire  = s_valid && s_ready;
  assign m_fire  = o_vld_q && m_ready;

  // ---- next-state: FSM, assembly slot write, output buffer ----
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    o_d     = o_q;
    o_vld_d = o_vld_q;
    err_d   = 1'b0;

    if (m_fire)
      o_vld_d = 1'b0;

    case (state_q)
      COLLECT: begin
        if (s_fire) begin
          a_d[idx_q*IN_BW +: IN_BW] = code;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            if (s_last) begin
              state_d = COMMIT;
            end else begin
              // Shot overran: flag once, then drop the rest up to s_last.
              err_d   = 1'b1;
              state_d = DISCARD;
            end
          end else if (s_last) begin
            idx_d = '0;
            err_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DISCARD: begin
        if (s_fire && s_last)
          state_d = COLLECT;
      end
      COMMIT: begin
        // A copy in the same cycle O is consumed keeps m_valid high with new data.
        if (!o_vld_q || m_ready) begin
          o_d     = a_q;
          o_vld_d = 1'b1;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // ---- register stage: control and output buffer ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      o_q     <= '0;
      o_vld_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      o_q     <= o_d;
      o_vld_q <= o_vld_d;
      err_q   <= err_d;
    end
  end

  // ---- register stage: assembly buffer (every slot rewritten per frame) ----
  always_ff @(posedge clk) begin
    a_q <= a_d;
  end

  assign m_valid = o_vld_q;
  assign m_data  = o_q;
  assign err_len = err_q;

endmodule

// File: tb/tb_qnet_input_quantizer.sv
module tb_qnet_input_quantizer;

  localparam int SW = 16;
  localparam int NF = 32;
  localparam int BW = 2;
  localparam int FW = NF * BW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [SW-1:0] s_data;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [FW-1:0] m_data;
  logic          err_len;

  always #5 clk = ~clk;

  qnet_input_quantizer #(
    .SAMPLE_W     (SW),
    .NUM_FEATURES (NF),
    .IN_BW        (BW),
    .SHIFT        (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .err_len (err_len)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model state: codes of the shot in progress, expected frames.
  int            cur[$];
  bit            discarding = 1'b0;
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] hist[$];
  int            err_exp    = 0;
  int            err_seen   = 0;
  int            frames_out = 0;

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] expv);
    compared++;
    assert (obs === expv)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Uniform quantizer with step 256, clipped to 0..3.
  function automatic int qref(input logic [SW-1:0] d);
    int v;
    v = int'($signed(d));
    if (v < 0) return 0;
    v = v / 256;
    return (v > 3) ? 3 : v;
  endfunction

  task automatic model_accept(input logic [SW-1:0] d, input bit last);
    logic [FW-1:0] f;
    if (discarding) begin
      if (last) discarding = 1'b0;
      return;
    end
    cur.push_back(qref(d));
    if (last) begin
      if (cur.size() == NF) begin
        f = '0;
        foreach (cur[i]) f |= 64'(cur[i]) << (BW * i);
        exp_q.push_back(f);
        hist.push_back(f);
      end else begin
        err_exp++;
      end
      cur.delete();
    end else if (cur.size() == NF) begin
      err_exp++;
      cur.delete();
      discarding = 1'b1;
    end
  endtask

  task automatic model_reset();
    cur.delete();
    discarding = 1'b0;
    exp_q.delete();
  endtask

  // Output monitor: frame scoreboard, hold stability, err pulse counting.
  logic          prev_hold = 1'b0;
  logic [FW-1:0] prev_d    = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 64'(m_valid), 64'd1);
        check("hold_data", m_data, prev_d);
      end
      if (err_len) err_seen++;
      if (m_valid && m_ready) begin
        frames_out++;
        check("frame_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("frame_data", m_data, exp_q.pop_front());
      end
      prev_hold = m_valid && !m_ready;
      prev_d    = m_data;
    end
  end

  function automatic logic [SW-1:0] rs();
    if ($urandom_range(0, 2) == 0) return SW'($urandom);
    return SW'($urandom_range(0, 1100));
  endfunction

  // Entered and left at posedge+1.
  task automatic send(input logic [SW-1:0] d, input bit last);
    int w = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    @(negedge clk);
    while (!s_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!s_ready) check("send_timeout", 64'(w), 64'd0);
    else model_accept(d, last);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_rand(input int n, input int last_at);
    for (int i = 1; i <= n; i++) send(rs(), i == last_at);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int e0;
    int f0;
    int w;
    logic [SW-1:0] pts[4];

    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", m_data, 64'd0);
    check("rst_err_len", 64'(err_len), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_s_ready", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;

    // Quantizer points in slots 0..3
    pts[0] = 16'h0150;
    pts[1] = 16'h0400;
    pts[2] = 16'hFFFB;
    pts[3] = 16'h00FF;
    for (int i = 0; i < NF; i++) send((i < 4) ? pts[i] : rs(), i == NF - 1);
    @(negedge clk);
    @(negedge clk);
    check("q_valid", 64'(m_valid), 64'd1);
    check("q_0x0150", 64'(m_data[1:0]), 64'd1);
    check("q_0x0400", 64'(m_data[3:2]), 64'd3);
    check("q_neg5", 64'(m_data[5:4]), 64'd0);
    check("q_0x00ff", 64'(m_data[7:6]), 64'd0);
    @(posedge clk);
    #1;
    idle(2);

    // Full frame of 0x0200, latency t+2, single-cycle valid
    for (int i = 0; i < NF; i++) send(16'h0200, i == NF - 1);
    @(negedge clk);
    check("lat_t1_valid", 64'(m_valid), 64'd0);
    @(negedge clk);
    check("lat_t2_valid", 64'(m_valid), 64'd1);
    check("lat_t2_data", m_data, 64'hAAAA_AAAA_AAAA_AAAA);
    @(negedge clk);
    check("lat_t3_valid", 64'(m_valid), 64'd0);
    @(posedge clk);
    #1;

    // Backpressure: two frames back-to-back with m_ready low
    m_ready = 1'b0;
    send_rand(NF, NF);
    send_rand(NF, NF);
    idle(3);
    @(negedge clk);
    check("bp_s_ready_low", 64'(s_ready), 64'd0);
    check("bp_m_valid", 64'(m_valid), 64'd1);
    check("bp_frame1", m_data, hist[hist.size() - 2]);
    @(posedge clk);
    #1;
    idle(12);
    m_ready = 1'b1;
    @(negedge clk);
    check("bp_s_ready_at_release", 64'(s_ready), 64'd0);
    @(negedge clk);
    check("bp_no_gap_valid", 64'(m_valid), 64'd1);
    check("bp_frame2", m_data, hist[hist.size() - 1]);
    check("bp_s_ready_back", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;
    idle(3);

    // Early s_last at sample 10
    e0 = err_seen;
    f0 = frames_out;
    for (int i = 1; i < 10; i++) send(rs(), 1'b0);
    send(rs(), 1'b1);
    @(negedge clk);
    check("early_err_pulse", 64'(err_len), 64'd1);
    @(posedge clk);
    #1;
    idle(5);
    check("early_err_count", 64'(err_seen - e0), 64'd1);
    check("early_no_frame", 64'(frames_out - f0), 64'd0);
    send_rand(NF, NF);
    idle(5);
    check("early_next_frame", 64'(frames_out - f0), 64'd1);

    // Missing s_last: 40 samples, s_last on the 40th
    e0 = err_seen;
    f0 = frames_out;
    for (int i = 1; i <= 40; i++) begin
      send(rs(), i == 40);
      if (i == NF) begin
        @(negedge clk);
        check("long_err_at_32", 64'(err_len), 64'd1);
        @(posedge clk);
        #1;
      end
    end
    idle(5);
    check("long_err_count", 64'(err_seen - e0), 64'd1);
    check("long_no_frame", 64'(frames_out - f0), 64'd0);
    f0 = frames_out;
    send_rand(NF, NF);
    idle(5);
    check("long_next_frame", 64'(frames_out - f0), 64'd1);

    // Reset mid-frame at idx 15
    for (int i = 0; i < 15; i++) send(rs(), 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_s_ready", 64'(s_ready), 64'd0);
    check("midrst_m_valid", 64'(m_valid), 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset while a frame is held on the output
    m_ready = 1'b0;
    send_rand(NF, NF);
    w = 0;
    while (!m_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("held_before_rst", 64'(m_valid), 64'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_drop_valid", 64'(m_valid), 64'd0);
    check("async_drop_data", m_data, 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_ready = 1'b1;
    f0 = frames_out;
    send_rand(NF, NF);
    idle(5);
    check("after_rst_frame", 64'(frames_out - f0), 64'd1);

    check("err_total", 64'(err_seen), 64'(err_exp));
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
